uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit; line idles high.
- Oversamples the raw rx pin with the system clock and samples each bit at its midpoint.
- Presents each received byte with a one-cycle completion pulse to the consuming logic, e.g. a command parser or RX FIFO.
- Pairs with the team's UART transmitter; uses the same CLK_FREQ/BAUD_RATE parameterisation.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings and
// the bit-timing derivation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ  = 50000000;
    localparam int unsigned DEFAULT_BAUD_RATE = 9600;

    // Clocks per bit; valid results lie in 4..65535 so they fit a 16-bit counter.
    function automatic int unsigned bit_period(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_period(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return bit_period(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input; both flops
// reset to RESET_VAL so an idle-high line does not look like an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, detects the start edge, samples every
// bit at its midpoint and reports each frame with a one-cycle pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_PERIOD = half_period(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

    rx_state_t   state, state_d;
    logic [15:0] clk_count, count_d;
    logic [2:0]  bit_index, index_d;
    logic [7:0]  shift, shift_d;
    logic [7:0]  data_d;
    logic        done_d, ferr_d, busy_d;
    logic        rx_sync, rx_prev;
    logic        start_edge;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) rx_prev <= 1'b1;
        else     rx_prev <= rx_sync;
    end

    // Only a genuine high-to-low transition starts a frame; a stuck-low line never does.
    assign start_edge = rx_prev & ~rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_count <= 16'd0;
            bit_index <= 3'd0;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            clk_count <= count_d;
            bit_index <= index_d;
            data      <= data_d;
            rx_done   <= done_d;
            frame_err <= ferr_d;
            busy      <= busy_d;
        end
    end

    // The shift register only carries payload; it is qualified by the FSM and needs no reset.
    always_ff @(posedge clk) begin
        shift <= shift_d;
    end

    always_comb begin
        state_d = state;
        count_d = clk_count + 16'd1;
        index_d = bit_index;
        shift_d = shift;
        data_d  = data;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy;

        case (state)
            IDLE: begin
                count_d = 16'd0;
                busy_d  = 1'b0;
                if (start_edge) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (clk_count == HALF_LAST) begin
                    count_d = 16'd0;
                    if (!rx_sync) begin
                        state_d = DATA;
                        index_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            DATA: begin
                if (clk_count == BIT_LAST) begin
                    count_d = 16'd0;
                    shift_d = {rx_sync, shift[7:1]};
                    index_d = bit_index + 3'd1;
                    if (bit_index == 3'd7) state_d = STOP;
                end
            end

            STOP: begin
                if (clk_count == BIT_LAST) begin
                    count_d = 16'd0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (rx_sync) begin
                        data_d = shift;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                count_d = 16'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit: scoreboard of expected
// bytes, pulse monitor, and directed frame/glitch/error/reset/phase scenarios.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD_RATE = 100000;
    localparam int BIT = 10;
    localparam int T   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_ferr   = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;
    int busy_cycles   = 0;
    logic done_prev = 1'b0;
    logic ferr_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(T/2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done) begin
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_rx_done", 32'd1, 32'd0);
            else check("rx_data", 32'(data), 32'(exp_q.pop_front()));
        end
        if (frame_err) n_ferr++;
        if (rx_done && frame_err) check("done_with_ferr", 32'd1, 32'd0);
        if (rx_done && done_prev) check("done_stretched", 32'd1, 32'd0);
        if (frame_err && ferr_prev) check("ferr_stretched", 32'd1, 32'd0);
        if (busy) busy_cycles++;
        done_prev = rx_done;
        ferr_prev = frame_err;
    end

    task automatic send_bit(input logic b);
        rx = b;
        #(BIT*T);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int f0;
        logic [7:0] b55;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(3);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clks(5);

        // single byte
        d0 = n_done; f0 = n_ferr;
        send_frame(8'hA5, 1'b1);
        wait_clks(20);
        check("a5_done_count", 32'(n_done - d0), 32'd1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("a5_busy_low", 32'(busy), 32'd0);

        // back-to-back frames, no idle gap
        d0 = n_done;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(20);
        check("b2b_done_count", 32'(n_done - d0), 32'd2);
        check("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd100);
        check("b2b_data", 32'(data), 32'hFF);

        // short low glitch
        d0 = n_done; f0 = n_ferr;
        busy_cycles = 0;
        rx = 1'b0;
        #(3*T);
        rx = 1'b1;
        wait_clks(30);
        check("glitch_busy_cycles", 32'(busy_cycles), 32'd5);
        check("glitch_no_done", 32'(n_done - d0), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("glitch_data", 32'(data), 32'hFF);

        // stop bit low, line then held low
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        busy_cycles = 0;
        #(50*T);
        check("ferr_count", 32'(n_ferr - f0), 32'd1);
        check("ferr_no_done", 32'(n_done - d0), 32'd0);
        check("ferr_data_kept", 32'(data), 32'hFF);
        check("ferr_no_retrigger", 32'(busy_cycles), 32'd0);
        rx = 1'b1;
        wait_clks(20);

        // reset in the middle of a frame
        b55 = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b55[i]);
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(1);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rx_done", 32'(rx_done), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        d0 = n_done; f0 = n_ferr;
        wait_clks(30);
        check("midrst_no_pulse", 32'(n_done - d0 + n_ferr - f0), 32'd0);
        send_frame(8'h81, 1'b1);
        wait_clks(20);
        check("after_rst_done", 32'(n_done - d0), 32'd1);
        check("after_rst_data", 32'(data), 32'h81);

        // phase sweep of the start edge
        for (int k = 0; k < 10; k++) begin
            d0 = n_done;
            repeat (k) @(posedge clk);
            @(posedge clk);
            #(0.5 + k);
            send_frame(8'h6E, 1'b1);
            wait_clks(20);
            check($sformatf("phase%0d_done", k), 32'(n_done - d0), 32'd1);
            check($sformatf("phase%0d_data", k), 32'(data), 32'h6E);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
